// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: tag/pointer widths,
// per-entry payload layout and the registered retire/flush output bundle.
package reorder_buffer_pkg;

  localparam int DEPTH = 16;
  localparam int TAG_W = 5;
  localparam int PTR_W = TAG_W - 1;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [XLEN-1:0]  word_t;
  typedef logic [REG_W-1:0] reg_t;

  localparam tag_t TAG_NONE = '1;

  typedef struct packed {
    reg_t  rd;
    logic  is_br;
    logic  is_st;
    word_t val;
    word_t target;
  } rob_payload_t;

  typedef struct packed {
    logic  commit;
    reg_t  rd;
    word_t val;
    tag_t  rename;
    logic  store;
    logic  flush;
    word_t flush_pc;
  } retire_out_t;

  // Only tags below DEPTH name real entries; TAG_NONE and the upper half never do.
  function automatic logic tag_in_range(input tag_t t);
    return t < tag_t'(DEPTH);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, writeback, operand-query and retire signals between the pipeline
// and the reorder buffer. The pipeline is the master, the ROB the slave.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic  issue;
  reg_t  issue_rd;
  logic  issue_is_br;
  logic  issue_is_st;
  logic  issue_ready;
  word_t issue_val;
  tag_t  issue_tag;
  logic  rob_full;

  logic  wb_valid;
  tag_t  wb_tag;
  word_t wb_val;
  logic  wb_mispred;
  word_t wb_target;

  tag_t  q1_tag, q2_tag;
  logic  q1_ready, q2_ready;
  word_t q1_val, q2_val;

  logic  commit;
  reg_t  commit_rd;
  word_t commit_val;
  tag_t  commit_rename;
  logic  commit_store;
  logic  flush_out;
  word_t flush_pc;

  modport master (
    output issue, issue_rd, issue_is_br, issue_is_st, issue_ready, issue_val,
    output wb_valid, wb_tag, wb_val, wb_mispred, wb_target, q1_tag, q2_tag,
    input  issue_tag, rob_full, q1_ready, q2_ready, q1_val, q2_val,
    input  commit, commit_rd, commit_val, commit_rename, commit_store, flush_out, flush_pc
  );

  modport slave (
    input  issue, issue_rd, issue_is_br, issue_is_st, issue_ready, issue_val,
    input  wb_valid, wb_tag, wb_val, wb_mispred, wb_target, q1_tag, q2_tag,
    output issue_tag, rob_full, q1_ready, q2_ready, q1_val, q2_val,
    output commit, commit_rd, commit_val, commit_rename, commit_store, flush_out, flush_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, completes from the CDB,
// retires one ready head per cycle and flushes when a mispredicted branch retires.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  reorder_buffer_if.slave rob
);

  ptr_t            head_q, head_d, tail_q, tail_d;
  tag_t            count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, mispred_q, mispred_d;
  retire_out_t     out_q, out_d;
  rob_payload_t    payload_q [DEPTH];

  logic  wb_valid;
  tag_t  wb_tag;
  word_t wb_val;
  ptr_t  wb_idx;
  logic  full, wb_hit, do_issue, do_retire, do_flush;

  assign wb_valid = rob.wb_valid;
  assign wb_tag   = rob.wb_tag;
  assign wb_val   = rob.wb_val;
  assign wb_idx   = wb_tag[PTR_W-1:0];

  assign full      = (count_q == tag_t'(DEPTH));
  assign wb_hit    = rdy_in && wb_valid && tag_in_range(wb_tag) && busy_q[wb_idx];
  assign do_issue  = rdy_in && rob.issue && !full;
  assign do_retire = rdy_in && (count_q != '0) && ready_q[head_q];
  assign do_flush  = do_retire && mispred_q[head_q];

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    mispred_d = mispred_q;
    out_d        = out_q;
    out_d.commit = 1'b0;
    out_d.store  = 1'b0;
    out_d.flush  = 1'b0;

    // Writeback lands before retire so a same-edge retire of that entry still frees it cleanly.
    if (wb_hit) begin
      ready_d[wb_idx]   = 1'b1;
      mispred_d[wb_idx] = rob.wb_mispred && payload_q[wb_idx].is_br;
    end

    if (do_retire) begin
      out_d.commit      = 1'b1;
      out_d.rd          = payload_q[head_q].rd;
      out_d.val         = payload_q[head_q].val;
      out_d.rename      = tag_t'(head_q);
      out_d.store       = payload_q[head_q].is_st;
      busy_d[head_q]    = 1'b0;
      ready_d[head_q]   = 1'b0;
      mispred_d[head_q] = 1'b0;
      head_d            = head_q + ptr_t'(1);
    end

    if (do_issue) begin
      busy_d[tail_q]    = 1'b1;
      ready_d[tail_q]   = rob.issue_ready;
      mispred_d[tail_q] = 1'b0;
      tail_d            = tail_q + ptr_t'(1);
    end

    count_d = count_q + tag_t'(do_issue) - tag_t'(do_retire);

    if (do_flush) begin
      out_d.flush    = 1'b1;
      out_d.flush_pc = payload_q[head_q].target;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      busy_d    = '0;
      ready_d   = '0;
      mispred_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      ready_q   <= '0;
      mispred_q <= '0;
      out_q     <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      mispred_q <= mispred_d;
      out_q     <= out_d;
    end
  end

  // NOTE: payload storage is not reset; busy/ready gate every read, so stale contents are never visible.
  always_ff @(posedge clk_in) begin
    if (do_issue) begin
      payload_q[tail_q].rd    <= rob.issue_rd;
      payload_q[tail_q].is_br <= rob.issue_is_br;
      payload_q[tail_q].is_st <= rob.issue_is_st;
      payload_q[tail_q].val   <= rob.issue_val;
    end
    if (wb_hit) begin
      payload_q[wb_idx].val    <= wb_val;
      payload_q[wb_idx].target <= rob.wb_target;
    end
  end

  // Returns {ready, value}; a result on the CDB this cycle is forwarded ahead of storage.
  function automatic logic [XLEN:0] query(input tag_t t);
    ptr_t idx;
    idx = t[PTR_W-1:0];
    if (!tag_in_range(t))                 return '0;
    if (wb_valid && wb_tag == t)          return {1'b1, wb_val};
    if (busy_q[idx] && ready_q[idx])      return {1'b1, payload_q[idx].val};
    return '0;
  endfunction

  assign {rob.q1_ready, rob.q1_val} = query(rob.q1_tag);
  assign {rob.q2_ready, rob.q2_val} = query(rob.q2_tag);

  assign rob.issue_tag     = tag_t'(tail_q);
  assign rob.rob_full      = full;
  assign rob.commit        = out_q.commit;
  assign rob.commit_rd     = out_q.rd;
  assign rob.commit_val    = out_q.val;
  assign rob.commit_rename = out_q.rename;
  assign rob.commit_store  = out_q.store;
  assign rob.flush_out     = out_q.flush;
  assign rob.flush_pc      = out_q.flush_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: reset, in-order retire,
// full/wrap, out-of-order writeback, query forwarding, mispredict flush, rdy hold, mid-run reset.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  reorder_buffer_if rob_bus ();

  reorder_buffer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rob    (rob_bus)
  );

  always #5 clk_in = ~clk_in;

  // {commit, commit_store, commit_rd, commit_rename, commit_val}
  logic [43:0] commit_obs;
  assign commit_obs = {rob_bus.commit, rob_bus.commit_store, rob_bus.commit_rd,
                       rob_bus.commit_rename, rob_bus.commit_val};

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rob_bus.issue = 0; rob_bus.issue_rd = '0; rob_bus.issue_is_br = 0; rob_bus.issue_is_st = 0;
    rob_bus.issue_ready = 0; rob_bus.issue_val = '0;
    rob_bus.wb_valid = 0; rob_bus.wb_tag = '0; rob_bus.wb_val = '0; rob_bus.wb_mispred = 0;
    rob_bus.wb_target = '0; rob_bus.q1_tag = TAG_NONE; rob_bus.q2_tag = TAG_NONE;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rdy_in = 1;
    rst_in = 1;
    tick();
    rst_in = 0;
  endtask

  task automatic issue_op(input reg_t rd, input logic rdy, input word_t val,
                          input logic br, input logic st);
    rob_bus.issue = 1; rob_bus.issue_rd = rd; rob_bus.issue_ready = rdy;
    rob_bus.issue_val = val; rob_bus.issue_is_br = br; rob_bus.issue_is_st = st;
    tick();
    rob_bus.issue = 0;
  endtask

  task automatic wb_op(input tag_t tag, input word_t val, input logic mis, input word_t tgt);
    rob_bus.wb_valid = 1; rob_bus.wb_tag = tag; rob_bus.wb_val = val;
    rob_bus.wb_mispred = mis; rob_bus.wb_target = tgt;
    tick();
    rob_bus.wb_valid = 0; rob_bus.wb_mispred = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_in = 1;
    #1;
    n_cmp++;
    if ({commit_obs, rob_bus.flush_out, rob_bus.flush_pc} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h/%b/%h want all zero",
                        commit_obs, rob_bus.flush_out, rob_bus.flush_pc);
    end
    n_cmp++;
    if ({rob_bus.issue_tag, rob_bus.rob_full} !== 6'd0) begin
      n_err++; $display("FAIL reset_tail: got tag=%0d full=%b want 0/0",
                        rob_bus.issue_tag, rob_bus.rob_full);
    end
    tick();
    rst_in = 0;
  endtask

  task automatic test_basic();
    apply_reset();
    issue_op(5'd5, 0, '0, 0, 0);
    n_cmp++;
    if (rob_bus.issue_tag !== 5'd1) begin
      n_err++; $display("FAIL basic_tail: got %0d want 1", rob_bus.issue_tag);
    end
    wb_op(5'd0, 32'h1234, 0, '0);
    n_cmp++;
    if (rob_bus.commit !== 1'b0) begin
      n_err++; $display("FAIL basic_early_commit: got %b want 0", rob_bus.commit);
    end
    tick();
    n_cmp++;
    if (commit_obs !== {1'b1, 1'b0, 5'd5, 5'd0, 32'h1234}) begin
      n_err++; $display("FAIL basic_commit: got %h want %h", commit_obs,
                        {1'b1, 1'b0, 5'd5, 5'd0, 32'h1234});
    end
    tick();
    n_cmp++;
    if (rob_bus.commit !== 1'b0) begin
      n_err++; $display("FAIL basic_pulse_width: got %b want 0", rob_bus.commit);
    end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) issue_op(reg_t'(i + 1), 0, '0, 0, 0);
    n_cmp++;
    if ({rob_bus.rob_full, rob_bus.issue_tag} !== {1'b1, 5'd0}) begin
      n_err++; $display("FAIL full_after_16: got full=%b tag=%0d want 1/0",
                        rob_bus.rob_full, rob_bus.issue_tag);
    end
    issue_op(5'd31, 1, 32'hDEAD, 0, 0);
    n_cmp++;
    if ({rob_bus.rob_full, rob_bus.issue_tag, rob_bus.commit} !== {1'b1, 5'd0, 1'b0}) begin
      n_err++; $display("FAIL full_17th_ignored: got full=%b tag=%0d commit=%b want 1/0/0",
                        rob_bus.rob_full, rob_bus.issue_tag, rob_bus.commit);
    end
    wb_op(5'd0, 32'h55, 0, '0);
    tick();
    n_cmp++;
    if ({commit_obs, rob_bus.rob_full} !== {1'b1, 1'b0, 5'd1, 5'd0, 32'h55, 1'b0}) begin
      n_err++; $display("FAIL full_retire: got %h full=%b want %h full=0", commit_obs,
                        rob_bus.rob_full, {1'b1, 1'b0, 5'd1, 5'd0, 32'h55});
    end
  endtask

  task automatic test_ooo_wb();
    logic [43:0] exp_c [3];
    exp_c[0] = {1'b1, 1'b0, 5'd1, 5'd0, 32'h10};
    exp_c[1] = {1'b1, 1'b0, 5'd2, 5'd1, 32'h11};
    exp_c[2] = {1'b1, 1'b0, 5'd3, 5'd2, 32'h22};
    apply_reset();
    for (int i = 0; i < 3; i++) issue_op(reg_t'(i + 1), 0, '0, 0, 0);
    wb_op(5'd2, 32'h22, 0, '0);
    wb_op(5'd1, 32'h11, 0, '0);
    wb_op(5'd0, 32'h10, 0, '0);
    n_cmp++;
    if (rob_bus.commit !== 1'b0) begin
      n_err++; $display("FAIL ooo_no_early: got %b want 0", rob_bus.commit);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (commit_obs !== exp_c[i]) begin
        n_err++; $display("FAIL ooo_commit%0d: got %h want %h", i, commit_obs, exp_c[i]);
      end
    end
    tick();
    n_cmp++;
    if (rob_bus.commit !== 1'b0) begin
      n_err++; $display("FAIL ooo_drained: got %b want 0", rob_bus.commit);
    end
  endtask

  task automatic test_query();
    apply_reset();
    for (int i = 0; i < 4; i++) issue_op(reg_t'(i + 1), 0, '0, 0, 0);
    rob_bus.q1_tag = 5'd3; rob_bus.q2_tag = TAG_NONE;
    rob_bus.wb_valid = 1; rob_bus.wb_tag = 5'd3; rob_bus.wb_val = 32'hAB;
    #1;
    n_cmp++;
    if ({rob_bus.q1_ready, rob_bus.q1_val} !== {1'b1, 32'hAB}) begin
      n_err++; $display("FAIL query_forward: got %b/%h want 1/ab", rob_bus.q1_ready, rob_bus.q1_val);
    end
    n_cmp++;
    if ({rob_bus.q2_ready, rob_bus.q2_val} !== 33'd0) begin
      n_err++; $display("FAIL query_none: got %b/%h want 0/0", rob_bus.q2_ready, rob_bus.q2_val);
    end
    tick();
    rob_bus.wb_valid = 0;
    rob_bus.q2_tag = 5'd2;
    #1;
    n_cmp++;
    if ({rob_bus.q1_ready, rob_bus.q1_val, rob_bus.q2_ready} !== {1'b1, 32'hAB, 1'b0}) begin
      n_err++; $display("FAIL query_stored: got q1=%b/%h q2=%b want 1/ab/0",
                        rob_bus.q1_ready, rob_bus.q1_val, rob_bus.q2_ready);
    end
    rob_bus.q2_tag = 5'd5;
    #1;
    n_cmp++;
    if (rob_bus.q2_ready !== 1'b0) begin
      n_err++; $display("FAIL query_not_busy: got %b want 0", rob_bus.q2_ready);
    end
    rob_bus.q1_tag = TAG_NONE; rob_bus.q2_tag = TAG_NONE;
  endtask

  task automatic test_mispredict();
    apply_reset();
    issue_op(5'd1, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) issue_op(reg_t'(i + 2), 0, '0, 0, 0);
    wb_op(5'd0, 32'h8, 1, 32'h100);
    tick();
    n_cmp++;
    if ({commit_obs, rob_bus.flush_out, rob_bus.flush_pc} !==
        {1'b1, 1'b0, 5'd1, 5'd0, 32'h8, 1'b1, 32'h100}) begin
      n_err++; $display("FAIL mispred_flush: got %h flush=%b pc=%h want commit rd1 val8 flush pc 100",
                        commit_obs, rob_bus.flush_out, rob_bus.flush_pc);
    end
    n_cmp++;
    if ({rob_bus.issue_tag, rob_bus.rob_full} !== 6'd0) begin
      n_err++; $display("FAIL mispred_tail: got tag=%0d full=%b want 0/0",
                        rob_bus.issue_tag, rob_bus.rob_full);
    end
    wb_op(5'd1, 32'h77, 0, '0);
    rob_bus.q1_tag = 5'd1;
    #1;
    n_cmp++;
    if ({rob_bus.flush_out, rob_bus.commit, rob_bus.q1_ready} !== 3'b000) begin
      n_err++; $display("FAIL mispred_after: got flush=%b commit=%b q1rdy=%b want 000",
                        rob_bus.flush_out, rob_bus.commit, rob_bus.q1_ready);
    end
    tick();
    n_cmp++;
    if (rob_bus.commit !== 1'b0) begin
      n_err++; $display("FAIL mispred_squashed: got %b want 0", rob_bus.commit);
    end
    rob_bus.q1_tag = TAG_NONE;
  endtask

  task automatic test_rdy_hold();
    apply_reset();
    issue_op(5'd7, 1, 32'h77, 0, 1);
    rdy_in = 0;
    issue_op(5'd9, 1, 32'h99, 0, 0);
    n_cmp++;
    if ({rob_bus.commit, rob_bus.issue_tag} !== {1'b0, 5'd1}) begin
      n_err++; $display("FAIL rdy_hold: got commit=%b tag=%0d want 0/1", rob_bus.commit, rob_bus.issue_tag);
    end
    rdy_in = 1;
    tick();
    n_cmp++;
    if (commit_obs !== {1'b1, 1'b1, 5'd7, 5'd0, 32'h77}) begin
      n_err++; $display("FAIL rdy_store_commit: got %h want %h", commit_obs,
                        {1'b1, 1'b1, 5'd7, 5'd0, 32'h77});
    end
    tick();
    n_cmp++;
    if ({rob_bus.commit, rob_bus.commit_store} !== 2'b00) begin
      n_err++; $display("FAIL rdy_store_pulse: got %b%b want 00", rob_bus.commit, rob_bus.commit_store);
    end
  endtask

  task automatic test_mid_reset();
    int late_commits;
    apply_reset();
    for (int i = 0; i < 5; i++) issue_op(reg_t'(i + 1), 0, '0, 0, 0);
    wb_op(5'd0, 32'h99, 0, '0);
    tick();
    n_cmp++;
    if (commit_obs !== {1'b1, 1'b0, 5'd1, 5'd0, 32'h99}) begin
      n_err++; $display("FAIL midrst_pre_commit: got %h want %h", commit_obs,
                        {1'b1, 1'b0, 5'd1, 5'd0, 32'h99});
    end
    #2 rst_in = 1;
    #1;
    n_cmp++;
    if ({commit_obs, rob_bus.flush_out, rob_bus.issue_tag} !== '0) begin
      n_err++; $display("FAIL midrst_async: got %h flush=%b tag=%0d want all zero",
                        commit_obs, rob_bus.flush_out, rob_bus.issue_tag);
    end
    tick();
    rst_in = 0;
    late_commits = 0;
    rob_bus.wb_valid = 1; rob_bus.wb_tag = 5'd1; rob_bus.wb_val = 32'h5;
    for (int i = 0; i < 5; i++) begin
      tick();
      rob_bus.wb_valid = 0;
      if (rob_bus.commit !== 1'b0) late_commits++;
    end
    n_cmp++;
    if (late_commits != 0) begin
      n_err++; $display("FAIL midrst_no_commit: got %0d commits want 0", late_commits);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_ooo_wb();
    test_query();
    test_mispredict();
    test_rdy_hold();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
